muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencer for the multicycle mult/div resource. It sits between the main control unit and the iterative `mult`/`div` units. It accepts a one-cycle start request, pulses the selected unit, and counts its fixed iteration latency. It then writes HI/LO through the HI/LO source muxes and reports completion, so the control unit only waits on `busy`/`done`. It also detects divide-by-zero at issue and raises the exception request instead of running the divider.

## Interface
- `MULT_CYCLES`, default 32: cycles the `mult` unit needs after its start pulse; must be ≥1.
- `DIV_CYCLES`, default 32: cycles the `div` unit needs after its start pulse; must be ≥1.
- `CNT_W`, default 6: counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start_mult` in 1: one-cycle request from the control unit for a MULT/MULTU.
- `start_div` in 1: one-cycle request for a DIV/DIVU.
- `divisor` in 32: B-register value, sampled only in the cycle `start_div` is accepted.
- `abort` in 1: flush from the control unit (exception or reset sequence); cancels any operation.
- `mult_start` out 1: start pulse to `mult`.
- `div_start` out 1: start pulse to `div`.
- `hi_write` out 1: HI register write enable.
- `lo_write` out 1: LO register write enable.
- `hi_sel` out 1: muxHI select; 0 = mult result, 1 = div result.
- `lo_sel` out 1: muxLO select; 0 = mult result, 1 = div result.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `div0_exc` out 1: one-cycle divide-by-zero exception request.

## Operation
- States:
  - IDLE
  - MRUN
  - DRUN
  - WB
  - DONE
  - DZ
- All outputs are registered or decoded from state only. No combinational path runs from an input to an output.
- IDLE, on `start_mult`: go to MRUN and load counter with MULT_CYCLES-1.
- IDLE, on `start_div` with `divisor`≠0: go to DRUN and load counter with DIV_CYCLES-1.
- IDLE, on `start_div` with `divisor`==0: go to DZ. The divider is never started.
- `start_mult` and `start_div` both high in IDLE: mult wins and the div request is dropped.
- `mult_start` / `div_start` is high only in the first cycle of MRUN / DRUN.
- MRUN / DRUN: the counter decrements each cycle. When it is 0 in the current cycle, go to WB.
- `op` flag: a registered flag recording mult (0) or div (1), latched at issue. It drives `hi_sel` and `lo_sel` in all states and holds its value after completion.
- WB: `hi_write` and `lo_write` are high for exactly this cycle. Next state is DONE.
- DONE: `done` is high. Next state is IDLE.
- DZ: `div0_exc` is high for one cycle. No HI/LO write occurs, `done` stays low, and next state is IDLE.
- Starts seen while `busy` is high are ignored, not queued.
- `abort` is checked before everything else in every state. Next state is IDLE and the counter clears. A pending WB is suppressed, so HI/LO stay unchanged. `op` is kept.
- `abort` in the same cycle as a start in IDLE: the start is dropped.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, counter 0, `op` 0. All outputs are 0.
- Request sampled at edge t, with N = MULT_CYCLES or DIV_CYCLES:
  - Unit start pulse: cycle t+1.
  - RUN: cycles t+1 .. t+N.
  - WB (HI/LO written): cycle t+N+1.
  - `done`: cycle t+N+2.
  - IDLE: t+N+3, when a new start can be accepted.
- Start-to-done latency is N+2 cycles.
- Back-to-back throughput is one operation per N+3 cycles.
- Divide-by-zero: `div0_exc` in cycle t+1, back in IDLE at t+2.
- N=1 is legal: RUN lasts one cycle and the start pulse coincides with the last RUN cycle.
- `reset` asserted mid-operation returns to IDLE immediately, with no WB.

## Structure
- Package `muldiv_pkg` holds:
  - the state enum (IDLE, MRUN, DRUN, WB, DONE, DZ);
  - the select constants SEL_MULT=0 and SEL_DIV=1.
- One sub-module, `md_cycle_counter`: loadable down-counter with CNT_W bits, `load`, `value`, `clear`, and a `zero` flag.
- The FSM and output registers live in `muldiv_ctrl`. Total is roughly 150–250 lines.

## Test plan
- Reset, then `start_mult` at t with defaults → `mult_start` at t+1; `hi_write`=`lo_write`=1 and `hi_sel`=`lo_sel`=0 at t+33; `done` at t+34; `busy` low at t+35.
- `start_div`, `divisor`=7 → `div_start` at t+1; WB at t+33 with `hi_sel`=`lo_sel`=1; `done` at t+34.
- `start_div`, `divisor`=0 → `div0_exc` high only at t+1; no `div_start`, `hi_write` or `done`; IDLE at t+2.
- `start_mult` and `start_div` in the same cycle → mult path only; `start_div` pulsed at t+10 is ignored, so exactly one `done` at t+34.
- `abort` at t+20 of a div → IDLE at t+21; no `hi_write`/`lo_write`/`done`; a new `start_mult` at t+21 is accepted.
- MULT_CYCLES=1, plus async `reset` pulsed low mid-RUN in a second run → first run: WB at t+2, `done` at t+3; second run: outputs go to 0 without waiting for a clock edge and no WB occurs.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mult/div sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MRUN,
        DRUN,
        WB,
        DONE,
        DZ
    } mdState_t;

    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;

endpackage

// File: rtl/md_cycle_counter.sv
// Loadable down-counter that saturates at zero; tracks remaining unit iterations.
module md_cycle_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             clear,
    output logic             zero
);

    logic [CNT_W-1:0] countQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countQ <= '0;
        end else if (clear) begin
            countQ <= '0;
        end else if (load) begin
            countQ <= value;
        end else if (countQ != '0) begin
            countQ <= countQ - CNT_W'(1);
        end
    end

    assign zero = (countQ == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative mult/div units: issues the start pulse, waits out the
// fixed latency, writes HI/LO and signals completion or divide-by-zero.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] divisor,
    input  logic        abort,
    output logic        mult_start,
    output logic        div_start,
    output logic        hi_write,
    output logic        lo_write,
    output logic        hi_sel,
    output logic        lo_sel,
    output logic        busy,
    output logic        done,
    output logic        div0_exc
);

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

    mdState_t         stateQ, stateD;
    logic             opQ, opD;
    logic             firstQ, firstD;
    logic             cntLoad, cntClear, cntZero;
    logic [CNT_W-1:0] cntLoadVal;

    md_cycle_counter #(
        .CNT_W(CNT_W)
    ) uCounter (
        .clk  (clk),
        .reset(reset),
        .load (cntLoad),
        .value(cntLoadVal),
        .clear(cntClear),
        .zero (cntZero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            opQ    <= SEL_MULT;
            firstQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            opQ    <= opD;
            firstQ <= firstD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        opD        = opQ;
        firstD     = 1'b0;
        cntLoad    = 1'b0;
        cntClear   = 1'b0;
        cntLoadVal = '0;
        // Abort overrides everything, including a start arriving in IDLE.
        if (abort) begin
            stateD   = IDLE;
            cntClear = 1'b1;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (start_mult) begin
                        stateD     = MRUN;
                        opD        = SEL_MULT;
                        firstD     = 1'b1;
                        cntLoad    = 1'b1;
                        cntLoadVal = MultLoad;
                    end else if (start_div) begin
                        opD = SEL_DIV;
                        if (divisor != 32'd0) begin
                            stateD     = DRUN;
                            firstD     = 1'b1;
                            cntLoad    = 1'b1;
                            cntLoadVal = DivLoad;
                        end else begin
                            stateD = DZ;
                        end
                    end
                end
                MRUN, DRUN: begin
                    if (cntZero) begin
                        stateD = WB;
                    end
                end
                WB:      stateD = DONE;
                DONE:    stateD = IDLE;
                DZ:      stateD = IDLE;
                default: stateD = IDLE;
            endcase
        end
    end

    // Every output is a decode of registered state, so async reset clears them at once.
    assign mult_start = (stateQ == MRUN) && firstQ;
    assign div_start  = (stateQ == DRUN) && firstQ;
    assign hi_write   = (stateQ == WB);
    assign lo_write   = (stateQ == WB);
    assign hi_sel     = opQ;
    assign lo_sel     = opQ;
    assign busy       = (stateQ != IDLE);
    assign done       = (stateQ == DONE);
    assign div0_exc   = (stateQ == DZ);

endmodule
